onewire_master_link: RTL
========================

Name: onewire_master_link

Overview:
- Bus-master link layer for the One Wire Protocol: the stage that drives the slave's reset_checker, cmd_reciever, rom_reciever and data_reader.
- Generates reset pulses and samples presence; transmits bytes as write slots and receives bytes as read slots on the shared open-drain line.
- Sits between the master command sequencer (op/start/done handshake) and the pulled-up bus wire.
- Timing is derived from a microsecond prescaler so one design serves any clock frequency.

Parameters:
CLKS_PER_US, 50, clk cycles per microsecond (>=1)
T_RST_LOW, 480, reset pulse low time, us
T_PRES_SAMPLE, 70, presence sample point after reset release, us
T_RST_REC, 410, time from presence sample to end of reset sequence, us
T_SLOT, 60, write/read slot length measured from falling edge, us
T_LOW1, 6, low time for write-1 and for read-slot initiation, us
T_RD_SAMPLE, 15, read sample point from slot falling edge, us
T_REC, 10, recovery (bus released) after every slot, us

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset (reset=0 resets)
bus  inout  1  open-drain one-wire line: driven 0 or high-Z, never driven 1
start  input  1  one-cycle request; accepted only when busy=0
op  input  2  00 reset/presence, 01 write byte, 10 read byte, 11 reserved
tx_data  input  8  byte for write op, captured on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at completion of any op
presence  output  1  result of last reset op (1 = slave pulled low at sample point)
rx_data  output  8  byte assembled by last read op

Behaviour:
- Reset (reset=0, async): bus released (Z), busy=0, done=0, presence=0, rx_data=8'h00, state IDLE, prescaler, us counter and bit index cleared. Reset mid-operation releases the bus immediately; no done pulse.
- Bus input passes through a 2-flop synchronizer; every sample uses the synchronized value.
- Timer: prescaler counts 0..CLKS_PER_US-1. Its wrap advances the us counter. The us counter and prescaler clear on every state entry.
- States: IDLE, RST_LOW, RST_WAIT, RST_REC, SLOT_LOW, SLOT_HOLD, SLOT_REC, DONE.
- IDLE: on start && !busy, latch op and tx_data, set busy, bit index = 0.
  - op 00 -> RST_LOW.
  - op 01/10 -> SLOT_LOW.
  - op 11 -> DONE with no bus activity.
- RST_LOW: drive 0 for T_RST_LOW us, then release -> RST_WAIT.
- RST_WAIT: at T_PRES_SAMPLE us, presence <= ~bus_sync -> RST_REC.
- RST_REC: wait T_RST_REC us -> DONE.
- SLOT_LOW: drive 0.
  - Write bit 0 holds low for T_SLOT us.
  - Write bit 1 and read hold low for T_LOW1 us.
  - Then release -> SLOT_HOLD.
- SLOT_HOLD: wait until T_SLOT us from the slot falling edge. For a read op, shift in bus_sync at T_RD_SAMPLE us into bit position bit_index -> SLOT_REC.
- SLOT_REC: released for T_REC us.
  - If bit_index==7 -> DONE.
  - Otherwise bit_index+1 -> SLOT_LOW.
- Bit order is LSB first for both tx and rx. rx_data updates only when a read op completes; a partial read never changes it.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle -> IDLE. A new start is accepted no earlier than the following cycle.
- start while busy=1 is ignored and has no effect on the op in flight.
- presence holds its value until the next reset op's sample point.
- Byte op duration: 8*(T_SLOT+T_REC) us. Reset op duration: T_RST_LOW+T_PRES_SAMPLE+T_RST_REC us. Each adds ±2 cycles of fixed sync/entry overhead, documented in the bench.

Test Plan:
- CLKS_PER_US=1, op=00, slave model pulls bus low for us 20..140 after release: bus low exactly 480 cycles, then presence=1, one done pulse, busy high for ~960 cycles.
- Same with no slave attached (bus pulled up): presence=0, done pulses, timing identical.
- op=01, tx_data=8'hA5: 8 slots, low times 6,60,6,60,60,6,60,6 us (LSB first). Each slot is followed by ≥10 us release, then one done pulse.
- op=10, slave model drives 8'h3C (holds low to 30 us for 0 bits): rx_data=8'h3C after done, and is unchanged during the op.
- Assert start with op=01 mid-read-op: ignored, read op completes unchanged. Then op=11: done one cycle after start, bus never low.
- Assert reset=0 during the SLOT_LOW of bit 3 of a write: bus released within the same cycle, busy=0, no done. A subsequent op=00 runs normally.

Source files
------------

// File: rtl/onewire_master_link.sv
// One-wire bus master link layer: reset/presence pulses, write slots and read slots
// on an open-drain line, timed from a microsecond prescaler.
module onewire_master_link #(
    parameter int CLKS_PER_US   = 50,
    parameter int T_RST_LOW     = 480,
    parameter int T_PRES_SAMPLE = 70,
    parameter int T_RST_REC     = 410,
    parameter int T_SLOT        = 60,
    parameter int T_LOW1        = 6,
    parameter int T_RD_SAMPLE   = 15,
    parameter int T_REC         = 10
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        bus,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       presence,
    output logic [7:0] rx_data
);
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int UW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LOW, S_RST_WAIT, S_RST_REC,
        S_SLOT_LOW, S_SLOT_HOLD, S_SLOT_REC, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [PW-1:0] r_pre;
    logic [UW-1:0] r_us;
    logic          r_bus_s1, r_bus_s2;
    logic [1:0]    r_op;
    logic [7:0]    r_tx, r_shift;
    logic [2:0]    r_bit;
    logic          w_tick, w_drive, w_low_long, w_rd_sample;
    logic [UW-1:0] w_low_us;

    assign bus    = w_drive ? 1'b0 : 1'bz;
    assign busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done   = (r_state == S_DONE);
    assign w_tick = (r_pre == PW'(CLKS_PER_US - 1));

    // A write-0 slot is low for the whole slot, so it has no hold phase.
    assign w_low_long  = (r_op == 2'b01) && !r_tx[r_bit];
    assign w_low_us    = w_low_long ? UW'(T_SLOT) : UW'(T_LOW1);
    // Hold phase starts T_LOW1 us after the falling edge.
    assign w_rd_sample = (r_state == S_SLOT_HOLD) && (r_op == 2'b10) && w_tick &&
                         (r_us == UW'(T_RD_SAMPLE - T_LOW1 - 1));

    always_comb begin
        w_next  = r_state;
        w_drive = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        2'b00:   w_next = S_RST_LOW;
                        2'b11:   w_next = S_DONE;
                        default: w_next = S_SLOT_LOW;
                    endcase
                end
            end
            S_RST_LOW: begin
                w_drive = 1'b1;
                if (w_tick && r_us == UW'(T_RST_LOW - 1)) w_next = S_RST_WAIT;
            end
            S_RST_WAIT: if (w_tick && r_us == UW'(T_PRES_SAMPLE - 1)) w_next = S_RST_REC;
            S_RST_REC:  if (w_tick && r_us == UW'(T_RST_REC - 1)) w_next = S_DONE;
            S_SLOT_LOW: begin
                w_drive = 1'b1;
                if (w_tick && r_us == w_low_us - UW'(1))
                    w_next = w_low_long ? S_SLOT_REC : S_SLOT_HOLD;
            end
            S_SLOT_HOLD: if (w_tick && r_us == UW'(T_SLOT - T_LOW1 - 1)) w_next = S_SLOT_REC;
            S_SLOT_REC: begin
                if (w_tick && r_us == UW'(T_REC - 1))
                    w_next = (r_bit == 3'd7) ? S_DONE : S_SLOT_LOW;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pre    <= '0;
            r_us     <= '0;
            r_bus_s1 <= 1'b1;
            r_bus_s2 <= 1'b1;
            r_op     <= 2'b00;
            r_tx     <= 8'h00;
            r_shift  <= 8'h00;
            r_bit    <= 3'd0;
            presence <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            r_state  <= w_next;
            r_bus_s1 <= bus;
            r_bus_s2 <= r_bus_s1;

            if (w_next != r_state || r_state == S_IDLE) begin
                r_pre <= '0;
                r_us  <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_us  <= r_us + UW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end

            if (r_state == S_IDLE && start) begin
                r_op  <= op;
                r_tx  <= tx_data;
                r_bit <= 3'd0;
            end
            if (w_rd_sample)
                r_shift[r_bit] <= r_bus_s2;
            if (r_state == S_SLOT_REC && w_next == S_SLOT_LOW)
                r_bit <= r_bit + 3'd1;
            if (r_state == S_SLOT_REC && w_next == S_DONE && r_op == 2'b10)
                rx_data <= r_shift;
            if (r_state == S_RST_WAIT && w_next == S_RST_REC)
                presence <= ~r_bus_s2;
        end
    end
endmodule
